// File: rtl/dsp_result_streamer.sv
// Captures the DSP product buses once the design has settled after reset and streams them
// as one framed byte stream: HEADER, NUM_CH*8 data bytes (ch0 first, LSB first), XOR checksum.
module dsp_result_streamer #(
  parameter int          NUM_CH        = 5,
  parameter int          WORD_BYTES    = 8,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [7:0]  HEADER        = 8'hA5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH*64-1:0]   products,
  input  logic                   start,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);
  localparam int W  = NUM_CH*64;
  localparam int NB = NUM_CH*WORD_BYTES;
  localparam int IW = $clog2(NB+2);
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES+1) : 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(NB);
  localparam logic [IW-1:0] CHK_IDX   = IW'(NB+1);

  typedef enum logic [1:0] {ST_SETTLE, ST_SEND, ST_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  snap;
  logic [IW-1:0] idx;
  logic [7:0]    chk, chk_n;

  // idx is the position of the byte currently presented; index 0 is the header,
  // which stays out of the checksum.
  always_comb begin
    chk_n = chk;
    if (idx != '0) chk_n = chk ^ out_data;
  end

  // The snapshot is consumed as a shift register: its low byte is always the next data byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_SETTLE;
      cnt       <= '0;
      snap      <= '0;
      idx       <= '0;
      chk       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_SETTLE: begin
          busy <= 1'b1;
          if (cnt == CW'(SETTLE_CYCLES)) begin
            snap      <= products;
            out_data  <= HEADER;
            out_valid <= 1'b1;
            idx       <= '0;
            chk       <= '0;
            state     <= ST_SEND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx == CHK_IDX) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              idx <= idx + 1'b1;
              chk <= chk_n;
              if (idx == LAST_DATA) begin
                out_data <= chk_n;
              end else begin
                out_data <= snap[7:0];
                snap     <= snap >> 8;
              end
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            done  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        default: state <= ST_SETTLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dsp_result_streamer.sv
// Self-checking bench: random products and sink backpressure, frames compared against
// a byte-list model built directly from the frame format.
module tb_dsp_result_streamer;
  localparam int NUM_CH = 5;
  localparam int SETTLE = 16;
  localparam int NB     = NUM_CH*8;
  localparam int FL     = NB+2;
  localparam int W      = NUM_CH*64;

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [W-1:0] products = '0;
  logic [7:0]   out_data;
  logic         out_valid, busy, done;
  logic [7:0]   expf [FL];
  int           nchk = 0, npass = 0;

  always #5 clk = ~clk;

  dsp_result_streamer #(.NUM_CH(NUM_CH), .WORD_BYTES(8), .SETTLE_CYCLES(SETTLE), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .products(products), .start(start),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  task automatic make_frame(input logic [W-1:0] p);
    logic [7:0] x = 8'h00;
    expf[0] = 8'hA5;
    for (int i = 0; i < NB; i++) begin
      expf[i+1] = p[8*i +: 8];
      x ^= expf[i+1];
    end
    expf[FL-1] = x;
  endtask

  task automatic rand_products();
    for (int i = 0; i < W/32; i++) products[32*i +: 32] = $urandom;
  endtask

  // Called at posedge+1; counts edges from the next one until the header appears.
  task automatic wait_capture(input string nm);
    int k = 0;
    while (k < 200) begin
      @(posedge clk); #1; k++;
      if (k == 1) begin
        nchk++; if (busy !== 1'b1) $display("FAIL %s busy_edge1 got %b exp 1", nm, busy); else npass++;
      end
      if (out_valid === 1'b1) break;
    end
    nchk++; if (k != SETTLE+1) $display("FAIL %s capture_edge got %0d exp %0d", nm, k, SETTLE+1); else npass++;
    nchk++; if (out_data !== 8'hA5) $display("FAIL %s header got %h exp a5", nm, out_data); else npass++;
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready.
  task automatic recv_frame(input int mode, input string nm);
    int   pos = 0, cyc = 0;
    logic r;
    while (pos < FL && cyc < 2000) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      nchk++;
      if ({out_valid, out_data} !== {1'b1, expf[pos]})
        $display("FAIL %s byte%0d got v=%b d=%h exp v=1 d=%h", nm, pos, out_valid, out_data, expf[pos]);
      else npass++;
      nchk++;
      if ({busy, done} !== 2'b10) $display("FAIL %s busy_done byte%0d got %b%b exp 10", nm, pos, busy, done);
      else npass++;
      @(posedge clk); #1; cyc++;
      if (r) pos++;
    end
    out_ready = 1'b0;
    nchk++; if (pos != FL) $display("FAIL %s frame_len got %0d exp %0d", nm, pos, FL); else npass++;
    if (mode == 0) begin
      nchk++; if (cyc != FL) $display("FAIL %s frame_edges got %0d exp %0d", nm, cyc, FL); else npass++;
    end
    nchk++;
    if ({out_valid, busy, done} !== 3'b001) $display("FAIL %s end_flags got %b%b%b exp 001", nm, out_valid, busy, done);
    else npass++;
    repeat (3) @(posedge clk); #1;
    nchk++;
    if ({out_valid, busy, done, out_data} !== {3'b001, expf[FL-1]})
      $display("FAIL %s done_hold got %b%b%b %h exp 001 %h", nm, out_valid, busy, done, out_data, expf[FL-1]);
    else npass++;
  endtask

  task automatic rearm(input string nm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nchk++;
    if ({done, busy, out_valid} !== 3'b010) $display("FAIL %s rearm got %b%b%b exp 010", nm, done, busy, out_valid);
    else npass++;
  endtask

  task automatic test_reset();
    #2;
    nchk++;
    if ({out_valid, busy, done, out_data} !== 11'h0) $display("FAIL reset_async got %b%b%b %h exp 000 00", out_valid, busy, done, out_data);
    else npass++;
    repeat (3) @(posedge clk); #1;
    nchk++;
    if ({out_valid, busy, done, out_data} !== 11'h0) $display("FAIL reset_held got %b%b%b %h exp 000 00", out_valid, busy, done, out_data);
    else npass++;
  endtask

  task automatic test_basic();
    products = '0;
    products[63:0] = 64'h0F18;
    make_frame(products);
    reset = 1'b0;
    wait_capture("basic");
    recv_frame(0, "basic");
  endtask

  task automatic test_stall();
    rearm("stall");
    wait_capture("stall");
    recv_frame(1, "stall");
  endtask

  task automatic test_snapshot();
    rand_products();
    make_frame(products);
    rearm("snap");
    wait_capture("snap");
    products = '1;
    recv_frame(2, "snap");
  endtask

  task automatic test_reset_mid();
    rand_products();
    make_frame(products);
    rearm("rstmid");
    wait_capture("rstmid");
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    nchk++; if (out_data !== expf[10]) $display("FAIL rstmid byte10 got %h exp %h", out_data, expf[10]); else npass++;
    reset = 1'b1;
    #1;
    nchk++;
    if ({out_valid, busy, done, out_data} !== 11'h0) $display("FAIL rstmid async got %b%b%b %h exp 000 00", out_valid, busy, done, out_data);
    else npass++;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rand_products();
    make_frame(products);
    reset = 1'b0;
    wait_capture("rstmid_after");
    recv_frame(2, "rstmid_after");
  endtask

  task automatic test_start();
    rand_products();
    make_frame(products);
    start = 1'b1;
    @(posedge clk); #1;
    nchk++; if ({done, busy} !== 2'b01) $display("FAIL start_done got %b%b exp 01", done, busy); else npass++;
    wait_capture("start");
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if ({out_valid, out_data, busy, done} !== {1'b1, 8'hA5, 2'b10})
      $display("FAIL start_in_send got %b %h %b%b exp 1 a5 10", out_valid, out_data, busy, done);
    else npass++;
    start = 1'b0;
    recv_frame(0, "start");
  endtask

  task automatic test_all_ones();
    products = '1;
    make_frame(products);
    rearm("ones");
    wait_capture("ones");
    recv_frame(0, "ones");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      rand_products();
      make_frame(products);
      rearm("rand");
      wait_capture("rand");
      recv_frame(2, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_reset_mid();
    test_start();
    test_all_ones();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end
endmodule
